// File: rtl/spi_rx.sv
// Bit-serial receiver: collects WIDTH MSB-first bits into a word and offers it
// on a valid/ready port, with restart, inter-bit timeout and overrun handling.
module spi_rx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             restart,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH:0]    sh_cat;
    logic [WIDTH-1:0]  shifted;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [GW-1:0]     gap;
    logic              start_bit, complete, timeout, discard;

    // Concatenate then slice so WIDTH=1 needs no special case.
    assign sh_cat  = {shreg, bit_in};
    assign shifted = sh_cat[WIDTH-1:0];
    assign busy    = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bit_valid && !complete) state_nxt = SHIFT;
            SHIFT: begin
                if (restart)        state_nxt = bit_valid ? SHIFT : IDLE;
                else if (bit_valid) state_nxt = complete ? IDLE : SHIFT;
                else if (timeout)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_bit = bit_valid && ((state == IDLE) || restart);
        cnt_nxt   = start_bit ? CW'(1) : cnt + CW'(1);
        complete  = bit_valid && (cnt_nxt == CW'(WIDTH));
        timeout   = (TIMEOUT > 0) && (state == SHIFT) && !bit_valid && !restart &&
                    (gap + GW'(1) == GW'(TIMEOUT));
        discard   = (state == SHIFT) && (restart || timeout);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg     <= '0;
            cnt       <= '0;
            gap       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= discard;
            if (bit_valid) shreg <= shifted;

            if (complete || (discard && !bit_valid)) cnt <= '0;
            else if (bit_valid)                      cnt <= cnt_nxt;

            if (state == SHIFT && !bit_valid && !discard) gap <= gap + GW'(1);
            else                                          gap <= '0;

            // A completion on a transfer edge simply replaces the consumed word.
            if (complete) begin
                data_out  <= shifted;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) overrun <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
